digital_tube_ctrl_gen: RTL and testbench

- Parametrised next-generation 7-segment controller. Drives DIGITS common-anode digits (segments active-low) from one of three sources: packed BCD, packed hex, or a binary value converted to decimal in-block.
- Adds source-mode select, an iterative binary-to-BCD converter with busy/overflow flags, leading-zero blanking, per-digit blink and display enable.
- Sits between datapath/counters and the board HEX pins; replaces fixed 6-digit BCD-only decoding.

---
 rtl/digital_tube_ctrl_gen.sv | 176 +++++++++++++++++
 tb/tb_digital_tube_ctrl_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/digital_tube_ctrl_gen.sv
// Multi-digit common-anode 7-segment controller: BCD, hex or binary-to-decimal
// sources with blanking, blink, overflow dashes and display enable.

module digital_tube_lane (
  input  logic [3:0] nib,
  input  logic       hex_mode,
  input  logic       en,
  input  logic       dash,
  input  logic       hide,
  input  logic       lz_hit,
  output logic [6:0] seg
);
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;

  logic [6:0] glyph;

  always_comb begin
    glyph = BLANK;
    case (nib)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0011000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      4'hF: glyph = 7'b0001110;
      default: glyph = BLANK;
    endcase
    if (!hex_mode && nib > 4'd9) glyph = BLANK;
  end

  // Later assignments win: enable > overflow > blink > leading-zero > glyph.
  always_comb begin
    seg = glyph;
    if (lz_hit) seg = BLANK;
    if (hide)   seg = BLANK;
    if (dash)   seg = DASH;
    if (!en)    seg = BLANK;
  end
endmodule

module digital_tube_ctrl_gen #(
  parameter int DIGITS     = 6,
  parameter int BIN_W      = 20,
  parameter int BLINK_HALF = 25000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  display_enable,
  input  logic                  load,
  input  logic [1:0]            mode,
  input  logic [4*DIGITS-1:0]   display_num,
  input  logic [BIN_W-1:0]      bin_num,
  input  logic                  lz_blank,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic                  busy,
  output logic                  ovf,
  output logic [7*DIGITS-1:0]   hex_out
);
  localparam int NW = 4*DIGITS;
  localparam int CW = $clog2(BIN_W+1);
  localparam int BW = $clog2(BLINK_HALF);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);

  logic [NW-1:0]     store;
  logic              hex_q;
  logic [BIN_W-1:0]  shreg;
  logic [NW-1:0]     acc, adj, acc_next;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bcnt;
  logic              phase;
  logic              accept;
  logic              lz_run;
  logic [DIGITS-1:0] lz_hit;
  logic [7*DIGITS-1:0] seg_next;

  assign accept = load && !busy;

  // One double-dabble step: add 3 to nibbles >= 5, then shift in next MSB.
  always_comb begin
    adj = acc;
    for (int i = 0; i < DIGITS; i++)
      if (acc[4*i+:4] >= 4'd5) adj[4*i+:4] = acc[4*i+:4] + 4'd3;
    acc_next = {adj[NW-2:0], shreg[BIN_W-1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store <= '0;
      hex_q <= 1'b0;
      busy  <= 1'b0;
      ovf   <= 1'b0;
      shreg <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (accept) begin
      if (mode == 2'b10) begin
        busy  <= 1'b1;
        shreg <= bin_num;
        acc   <= '0;
        cnt   <= '0;
        ovf   <= 64'(bin_num) >= LIMIT;
      end else begin
        store <= display_num;
        hex_q <= (mode == 2'b01);
        ovf   <= 1'b0;
      end
    end else if (busy) begin
      acc   <= acc_next;
      shreg <= shreg << 1;
      cnt   <= cnt + CW'(1);
      if (cnt == CW'(BIN_W-1)) begin
        store <= acc_next;
        hex_q <= 1'b0;
        busy  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bcnt == BW'(BLINK_HALF-1)) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt  <= bcnt + BW'(1);
    end
  end

  // Digit i is a leading zero when it and every digit above it are zero.
  always_comb begin
    lz_run = 1'b1;
    lz_hit = '0;
    for (int i = DIGITS-1; i >= 0; i--) begin
      lz_run    = lz_run && (store[4*i+:4] == 4'd0);
      lz_hit[i] = lz_run && (i != 0) && lz_blank && !hex_q;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_lane
    digital_tube_lane u_lane (
      .nib      (store[4*g+:4]),
      .hex_mode (hex_q),
      .en       (display_enable),
      .dash     (ovf),
      .hide     (phase && blink_mask[g]),
      .lz_hit   (lz_hit[g]),
      .seg      (seg_next[7*g+:7])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hex_out <= {DIGITS{7'b1000000}};
    else        hex_out <= seg_next;
  end
endmodule

// File: tb/tb_digital_tube_ctrl_gen.sv
// Randomised self-checking bench for digital_tube_ctrl_gen against a
// value-level display model.

module tb_digital_tube_ctrl_gen;
  localparam int D  = 6;
  localparam int BW = 20;
  localparam int BH = 4;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [41:0] RST_OUT = {6{7'b1000000}};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        display_enable = 1'b0;
  logic        load = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [23:0] display_num = '0;
  logic [19:0] bin_num = '0;
  logic        lz_blank = 1'b0;
  logic [5:0]  blink_mask = '0;
  logic        busy, ovf;
  logic [41:0] hex_out;

  digital_tube_ctrl_gen #(.DIGITS(D), .BIN_W(BW), .BLINK_HALF(BH)) dut (
    .clk(clk), .rst_n(rst_n), .display_enable(display_enable), .load(load),
    .mode(mode), .display_num(display_num), .bin_num(bin_num),
    .lz_blank(lz_blank), .blink_mask(blink_mask), .busy(busy), .ovf(ovf),
    .hex_out(hex_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  // Edges clocked since reset release; sets the expected blink phase.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  logic [6:0] GL [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                          7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic [23:0] m_nibs;
  bit          m_hex;
  bit          m_ovf;

  function automatic logic [23:0] to_bcd(input int unsigned v);
    logic [23:0] r;
    int unsigned p;
    r = '0;
    p = 1;
    for (int i = 0; i < D; i++) begin
      r[4*i+:4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [41:0] expect_out();
    logic [41:0] r;
    logic [3:0]  nb;
    logic [6:0]  s;
    bit          hidden;
    hidden = (((cyc - 1) / BH) % 2) == 1;
    r = '0;
    for (int i = 0; i < D; i++) begin
      nb = m_nibs[4*i+:4];
      s  = GL[nb];
      if (!m_hex && nb > 4'd9) s = BLANK;
      if (lz_blank && !m_hex && i > 0 && (m_nibs >> (4*i)) == 24'd0) s = BLANK;
      if (hidden && blink_mask[i]) s = BLANK;
      if (m_ovf) s = DASH;
      if (!display_enable) s = BLANK;
      r[7*i+:7] = s;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic direct_load(input logic [1:0] md, input logic [23:0] num);
    mode = md;
    display_num = num;
    load = 1'b1;
    tick();
    load = 1'b0;
    m_nibs = num;
    m_hex  = (md == 2'b01);
    m_ovf  = 1'b0;
  endtask

  task automatic test_reset();
    logic [41:0] e;
    rst_n = 1'b0;
    display_enable = 1'b1;
    tick(); tick();
    n_cmp++; if (hex_out !== RST_OUT) begin n_bad++; $display("FAIL reset_hex: got %h want %h", hex_out, RST_OUT); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    rst_n = 1'b1;
    m_nibs = '0; m_hex = 1'b0; m_ovf = 1'b0;
    tick();
    e = expect_out();
    n_cmp++; if (hex_out !== e || e !== RST_OUT) begin n_bad++; $display("FAIL reset_release: got %h want %h", hex_out, RST_OUT); end
  endtask

  task automatic test_bcd();
    logic [41:0] e;
    lz_blank = 1'b0;
    direct_load(2'b00, 24'h12345A);
    tick();
    e = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, BLANK};
    n_cmp++; if (hex_out !== e) begin n_bad++; $display("FAIL bcd_plan: got %h want %h", hex_out, e); end
    for (int k = 0; k < 8; k++) begin
      lz_blank = 1'($urandom);
      direct_load($urandom_range(0, 1) ? 2'b00 : 2'b11,
                  (k < 3) ? (24'($urandom) >> (4 * (k + 2))) : 24'($urandom));
      tick();
      e = expect_out();
      n_cmp++; if (hex_out !== e) begin n_bad++; $display("FAIL bcd_rand%0d: got %h want %h", k, hex_out, e); end
    end
    // Back-to-back loads: the second one wins.
    lz_blank = 1'b1;
    direct_load(2'b00, 24'h999999);
    direct_load(2'b00, 24'h000070);
    tick();
    e = expect_out();
    n_cmp++; if (hex_out !== e) begin n_bad++; $display("FAIL back_to_back: got %h want %h", hex_out, e); end
  endtask

  task automatic test_hex();
    logic [41:0] e;
    lz_blank = 1'b1;
    direct_load(2'b01, 24'h0000AF);
    tick();
    e = {{4{7'b1000000}}, 7'b0001000, 7'b0001110};
    n_cmp++; if (hex_out !== e) begin n_bad++; $display("FAIL hex_plan: got %h want %h", hex_out, e); end
    for (int k = 0; k < 6; k++) begin
      lz_blank = 1'($urandom);
      direct_load(2'b01, 24'($urandom));
      tick();
      e = expect_out();
      n_cmp++; if (hex_out !== e) begin n_bad++; $display("FAIL hex_rand%0d: got %h want %h", k, hex_out, e); end
    end
  endtask

  task automatic run_bin(input int unsigned v, input bit inject, input string tag);
    logic [41:0] e;
    int bc;
    mode = 2'b10;
    bin_num = 20'(v);
    load = 1'b1;
    tick();
    load = 1'b0;
    m_ovf = (v >= 1000000);
    n_cmp++; if (ovf !== m_ovf) begin n_bad++; $display("FAIL %s_ovf: got %b want %b", tag, ovf, m_ovf); end
    bc = 0;
    while (busy === 1'b1 && bc < 100) begin
      bc++;
      if (inject && bc == 5) begin
        load = 1'b1;
        bin_num = 20'($urandom);
        mode = 2'($urandom);
        display_num = 24'($urandom);
      end else begin
        load = 1'b0;
      end
      tick();
    end
    load = 1'b0;
    n_cmp++; if (bc != BW) begin n_bad++; $display("FAIL %s_busy_cycles: got %0d want %0d", tag, bc, BW); end
    m_nibs = to_bcd(v);
    m_hex  = 1'b0;
    tick();
    e = expect_out();
    n_cmp++; if (hex_out !== e) begin n_bad++; $display("FAIL %s_out: got %h want %h", tag, hex_out, e); end
  endtask

  task automatic test_binary();
    logic [41:0] e;
    lz_blank = 1'b1;
    run_bin(98765, 1'b1, "bin98765");
    e = {BLANK, 7'b0011000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010};
    n_cmp++; if (hex_out !== e) begin n_bad++; $display("FAIL bin_plan: got %h want %h", hex_out, e); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL bin_plan_ovf: got %b want 0", ovf); end
    run_bin(1000000, 1'b0, "bin_ovf");
    n_cmp++; if (hex_out !== {6{DASH}}) begin n_bad++; $display("FAIL ovf_dash: got %h want %h", hex_out, {6{DASH}}); end
    direct_load(2'b00, 24'h000123);
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b want 0", ovf); end
    tick();
    e = expect_out();
    n_cmp++; if (hex_out !== e) begin n_bad++; $display("FAIL ovf_clear_out: got %h want %h", hex_out, e); end
    run_bin(999999, 1'b0, "bin_max");
    run_bin(0, 1'b0, "bin_zero");
    for (int k = 0; k < 5; k++) begin
      lz_blank = 1'($urandom);
      run_bin($urandom_range(0, 20'hFFFFF), 1'($urandom), $sformatf("bin_rand%0d", k));
    end
  endtask

  task automatic test_blink();
    logic [41:0] e;
    int hid;
    lz_blank = 1'b0;
    direct_load(2'b00, 24'h123456);
    blink_mask = 6'b000001;
    hid = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      e = expect_out();
      if (hex_out[6:0] === BLANK) hid++;
      n_cmp++; if (hex_out !== e) begin n_bad++; $display("FAIL blink_c%0d: got %h want %h", k, hex_out, e); end
    end
    n_cmp++; if (hid != 8) begin n_bad++; $display("FAIL blink_hidden_count: got %0d want 8", hid); end
    blink_mask = '0;
  endtask

  task automatic test_enable();
    logic [41:0] e;
    display_enable = 1'b0;
    tick();
    n_cmp++; if (hex_out !== {6{BLANK}}) begin n_bad++; $display("FAIL disable_blank: got %h want %h", hex_out, {6{BLANK}}); end
    direct_load(2'b00, 24'h000042);
    tick();
    n_cmp++; if (hex_out !== {6{BLANK}}) begin n_bad++; $display("FAIL disable_load: got %h want %h", hex_out, {6{BLANK}}); end
    display_enable = 1'b1;
    tick();
    e = expect_out();
    n_cmp++; if (hex_out !== e) begin n_bad++; $display("FAIL reenable: got %h want %h", hex_out, e); end
  endtask

  task automatic test_reset_mid();
    logic [41:0] e;
    mode = 2'b10;
    bin_num = 20'hFFFFF;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick(); tick();
    n_cmp++; if (busy !== 1'b1 || ovf !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b%b want 11", busy, ovf); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || ovf !== 1'b0) begin n_bad++; $display("FAIL mid_reset_flags: got %b%b want 00", busy, ovf); end
    n_cmp++; if (hex_out !== RST_OUT) begin n_bad++; $display("FAIL mid_reset_hex: got %h want %h", hex_out, RST_OUT); end
    tick();
    rst_n = 1'b1;
    m_nibs = '0; m_hex = 1'b0; m_ovf = 1'b0;
    tick(); tick();
    e = expect_out();
    n_cmp++; if (hex_out !== e || busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_after: got %h/%b want %h/0", hex_out, busy, e); end
  endtask

  initial begin
    test_reset();
    test_bcd();
    test_hex();
    test_binary();
    test_blink();
    test_enable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
